// File: rtl/pipelined_cla_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Latency: two rising edges from capture to result (operand reg, then result reg).
// Backpressure: a full stage holds while the stage after it is stalled; at most 2 beats are in flight.
module pipelined_cla_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NG = WIDTH / GROUP;

  // Stage 1 state: stored operands (b already conditionally inverted) and effective carry-in
  logic             v1_q, v1_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c0_q, c0_d;

  // Stage 2 state: registered result
  logic             v2_q, v2_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic             en1, en2;

  // Combinational adder terms derived from stage 1
  logic [WIDTH-1:0] p, g;
  logic [NG-1:0]    pg, gg;
  logic [NG:0]      cg;     // carry into each group; cg[NG] is the final carry out
  logic [WIDTH:0]   c;      // carry into each bit; c[WIDTH] is the carry out of the MSB
  logic [WIDTH-1:0] s;

  // Stage enables: a stage may load when it is empty or its contents move on this cycle
  always_comb begin
    en2       = !v2_q || out_ready;
    en1       = !v1_q || en2;
    in_ready  = en1;
    out_valid = v2_q;
    sum       = sum_q;
    cout      = cout_q;
    ovf       = ovf_q;
    zero      = zero_q;
  end

  // Stage 1 next state: capture operands, folding subtraction into b inversion plus carry-in of 1
  always_comb begin
    a_d  = a_q;
    b_d  = b_q;
    c0_d = c0_q;
    v1_d = v1_q;
    if (en1) begin
      a_d  = a;
      b_d  = b ^ {WIDTH{sub}};
      c0_d = sub | cin;
      v1_d = in_valid;
    end
  end

  // Per-bit propagate/generate and per-group 4-bit lookahead propagate/generate
  always_comb begin
    p  = a_q ^ b_q;
    g  = a_q & b_q;
    pg = '0;
    gg = '0;
    for (int j = 0; j < NG; j++) begin
      pg[j] = p[GROUP*j+3] & p[GROUP*j+2] & p[GROUP*j+1] & p[GROUP*j];
      gg[j] = g[GROUP*j+3]
            | (p[GROUP*j+3] & g[GROUP*j+2])
            | (p[GROUP*j+3] & p[GROUP*j+2] & g[GROUP*j+1])
            | (p[GROUP*j+3] & p[GROUP*j+2] & p[GROUP*j+1] & g[GROUP*j]);
    end
  end

  // Second-level lookahead: each group carry is a flat sum of products over lower groups
  always_comb begin
    logic acc;
    logic term;
    cg = '0;
    for (int j = 0; j <= NG; j++) begin
      term = c0_q;
      for (int m = 0; m < j; m++) term = term & pg[m];
      acc = term;
      for (int k = 0; k < j; k++) begin
        term = gg[k];
        for (int m = k + 1; m < j; m++) term = term & pg[m];
        acc = acc | term;
      end
      cg[j] = acc;
    end
  end

  // Intra-group 4-bit lookahead carries and the final sum bits
  always_comb begin
    c = '0;
    for (int j = 0; j < NG; j++) begin
      c[GROUP*j]   = cg[j];
      c[GROUP*j+1] = g[GROUP*j] | (p[GROUP*j] & cg[j]);
      c[GROUP*j+2] = g[GROUP*j+1]
                   | (p[GROUP*j+1] & g[GROUP*j])
                   | (p[GROUP*j+1] & p[GROUP*j] & cg[j]);
      c[GROUP*j+3] = g[GROUP*j+2]
                   | (p[GROUP*j+2] & g[GROUP*j+1])
                   | (p[GROUP*j+2] & p[GROUP*j+1] & g[GROUP*j])
                   | (p[GROUP*j+2] & p[GROUP*j+1] & p[GROUP*j] & cg[j]);
    end
    c[WIDTH] = cg[NG];
    s = p ^ c[WIDTH-1:0];
  end

  // Stage 2 next state: capture result flags; overflow is carry-in vs carry-out of the MSB
  always_comb begin
    sum_d  = sum_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    zero_d = zero_q;
    v2_d   = v2_q;
    if (en2) begin
      sum_d  = s;
      cout_d = c[WIDTH];
      ovf_d  = c[WIDTH-1] ^ c[WIDTH];
      zero_d = ~|s;
      v2_d   = v1_q;
    end
  end

  // Pipeline registers; reset empties both stages and clears the visible result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      c0_q   <= 1'b0;
      v2_q   <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      v1_q   <= v1_d;
      a_q    <= a_d;
      b_q    <= b_d;
      c0_q   <= c0_d;
      v2_q   <= v2_d;
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder at WIDTH=16: directed vectors plus a random stream.
// Stimulus changes on the falling edge; handshakes are sampled 1 time unit before the rising edge.
// The monitor pops expected results independently of the stimulus thread.
module tb_pipelined_cla_adder;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    res_t        exp;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic        zero;

  int   checks;
  int   failures;
  res_t exp_q[$];
  vec_t dv[13];
  bit   rnd_done;

  pipelined_cla_adder #(.WIDTH(16), .GROUP(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [15:0] x, input logic [15:0] y, input logic ci,
                              input logic sb, input logic [15:0] s, input logic co,
                              input logic ov, input logic z);
    vec_t v;
    v.a = x; v.b = y; v.cin = ci; v.sub = sb;
    v.exp.sum = s; v.exp.cout = co; v.exp.ovf = ov; v.exp.zero = z;
    return v;
  endfunction

  // Reference: plain wide arithmetic, {cout,sum} = a + (sub ? ~b+1 : b+cin)
  function automatic res_t model(input logic [15:0] x, input logic [15:0] y,
                                 input logic ci, input logic sb);
    logic [16:0] full;
    logic [15:0] yb;
    res_t        r;
    yb     = sb ? ~y : y;
    full   = {1'b0, x} + {1'b0, yb} + {16'b0, (sb ? 1'b1 : ci)};
    r.sum  = full[15:0];
    r.cout = full[16];
    r.ovf  = (x[15] == yb[15]) && (full[15] != x[15]);
    r.zero = (full[15:0] == 16'h0000);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Offer one beat, hold it until accepted, push its expected result at the accepting edge
  task automatic send(input vec_t v, output int waited);
    a = v.a; b = v.b; cin = v.cin; sub = v.sub; in_valid = 1'b1;
    waited = 0;
    #4;
    while (!in_ready && waited < 100) begin
      @(negedge clk); #4;
      waited++;
    end
    if (in_ready) exp_q.push_back(v.exp);
    else begin
      checks++;
      failures++;
      $display("FAIL send_timeout a=%h b=%h in_ready stayed 0", v.a, v.b);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: every output transfer is compared against the oldest outstanding expectation
  initial begin
    res_t e;
    res_t got;
    forever begin
      @(negedge clk); #4;
      if (rst_n && out_valid && out_ready) begin
        got = {sum, cout, ovf, zero};
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output sum=%h cout=%b ovf=%b zero=%b", sum, cout, ovf, zero);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (got !== e) begin
            failures++;
            $display("FAIL result got sum=%h cout=%b ovf=%b zero=%b expected sum=%h cout=%b ovf=%b zero=%b",
                     got.sum, got.cout, got.ovf, got.zero, e.sum, e.cout, e.ovf, e.zero);
          end
        end
      end
    end
  end

  initial begin
    int w;
    int stalls;
    int acc;
    int nv;

    checks = 0; failures = 0; rnd_done = 1'b0;
    // Hand-computed vectors: a, b, cin, sub -> sum, cout, ovf, zero
    dv[0]  = mk(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    dv[1]  = mk(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    dv[2]  = mk(16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    dv[3]  = mk(16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);
    dv[4]  = mk(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0);
    dv[5]  = mk(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    dv[6]  = mk(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
    dv[7]  = mk(16'hAAAA, 16'hAAAA, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    dv[8]  = mk(16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0);
    dv[9]  = mk(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    dv[10] = mk(16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
    dv[11] = mk(16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
    dv[12] = mk(16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);

    rst_n = 1'b0; in_valid = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    // Reset state, with in_valid high throughout reset
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum",       32'(sum),       32'd0);
    check("rst_cout",      32'(cout),      32'd0);
    check("rst_ovf",       32'(ovf),       32'd0);
    check("rst_zero",      32'(zero),      32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_rst_out_valid", 32'(out_valid), 32'd0);

    // Latency: capture edge, then result register edge
    send(dv[0], w);
    check("lat_after_capture_edge", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_after_second_edge", 32'(out_valid), 32'd1);
    @(negedge clk);
    drain("lat_drain");

    // Back-to-back stream with out_ready=1: no stalls, results on consecutive cycles
    stalls = 0;
    fork
      begin
        for (int i = 1; i < 13; i++) begin
          send(dv[i], w);
          stalls += w;
        end
      end
      begin
        int n;
        int tmo;
        n = 0; tmo = 0;
        #4;
        while (!out_valid && tmo < 10) begin
          @(negedge clk); #4;
          tmo++;
        end
        for (int i = 0; i < 12; i++) begin
          if (out_valid) n++;
          @(negedge clk); #4;
        end
        check("stream_consecutive_outputs", 32'(n), 32'd12);
      end
    join
    check("stream_in_ready_stalls", 32'(stalls), 32'd0);
    @(negedge clk);
    drain("stream_drain");

    // Backpressure: out_ready low for 5 cycles while offering beats
    out_ready = 1'b0;
    acc = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      a = dv[5 + acc].a; b = dv[5 + acc].b; cin = dv[5 + acc].cin; sub = dv[5 + acc].sub;
      in_valid = 1'b1;
      #4;
      if (in_ready) begin
        exp_q.push_back(dv[5 + acc].exp);
        acc++;
      end
      if (cyc == 2) check("bp_hold_c2", 32'({out_valid, sum, cout, ovf, zero}), 32'({1'b1, dv[5].exp}));
      if (cyc == 4) begin
        check("bp_hold_c4", 32'({out_valid, sum, cout, ovf, zero}), 32'({1'b1, dv[5].exp}));
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
      end
      @(negedge clk);
    end
    check("bp_accepted", 32'(acc), 32'd2);
    in_valid = 1'b0;
    drain("bp_drain");

    // Reset with both stages full and a beat offered during reset
    out_ready = 1'b0;
    send(dv[10], w);
    send(dv[11], w);
    rst_n = 1'b0; out_ready = 1'b1;
    a = dv[12].a; b = dv[12].b; cin = dv[12].cin; sub = dv[12].sub; in_valid = 1'b1;
    @(posedge clk); #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_sum",       32'(sum),       32'd0);
    check("midrst_cout",      32'(cout),      32'd0);
    check("midrst_ovf",       32'(ovf),       32'd0);
    check("midrst_zero",      32'(zero),      32'd0);
    check("midrst_in_ready",  32'(in_ready),  32'd1);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    nv = 0;
    for (int i = 0; i < 6; i++) begin
      #4;
      if (out_valid) nv++;
      @(negedge clk);
    end
    check("midrst_no_stale", 32'(nv), 32'd0);

    // Random stream with random out_ready, checked against the arithmetic model
    fork
      begin
        vec_t v;
        logic [15:0] corner[4];
        corner[0] = 16'h0000; corner[1] = 16'hFFFF; corner[2] = 16'h8000; corner[3] = 16'h7FFF;
        for (int i = 0; i < 2000; i++) begin
          v.a   = ($urandom_range(3) == 0) ? corner[$urandom_range(3)] : 16'($urandom);
          v.b   = ($urandom_range(3) == 0) ? corner[$urandom_range(3)] : 16'($urandom);
          v.cin = 1'($urandom_range(1));
          v.sub = 1'($urandom_range(1));
          v.exp = model(v.a, v.b, v.cin, v.sub);
          send(v, w);
          if ($urandom_range(3) == 0) @(negedge clk);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          out_ready = 1'($urandom_range(1));
          @(negedge clk);
        end
      end
    join
    drain("rand_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
